cp0_intr_timer: RTL
===================

Name: cp0_intr_timer

Overview:
Produces the CP0 Cause.IP[7:0] vector that the commit stage masks with Status.IM/IE/EXL/ERL when deciding whether to raise EX_INT. Owns the architectural Count and Compare registers and the timer-interrupt (TI) flag. Synchronises the six external hardware interrupt pins into the clock domain. Sits directly upstream of commit in the reference CPU; the CP0 register file forwards MTC0 Count/Compare writes to it and reads its outputs back.

Parameters:
SYNC_STAGES, 2, number of flip-flops in each external-interrupt synchroniser chain (legal range 1..4)

Ports:
clk  input  1  clock
resetn  input  1  asynchronous reset, active low
ext_int  input  6  raw external hardware interrupt pins HW0..HW5, level-sensitive, asynchronous to clk
sw_ip  input  2  Cause.IP[1:0] software interrupt bits held in CP0
count_we  input  1  MTC0 write strobe for Count
count_wdata  input  32  new Count value
compare_we  input  1  MTC0 write strobe for Compare
compare_wdata  input  32  new Compare value
count  output  32  current Count register
compare  output  32  current Compare register
ti  output  1  timer interrupt flag (Cause.TI)
ip  output  8  Cause.IP vector consumed by commit

Behaviour:
- Clock and reset: one clock, clk; reset is resetn, asynchronous assert, active low, synchronous deassert handled upstream. All state flops reset asynchronously.
- Reset values:
  - count = 0, compare = 0, ti = 0.
  - All synchroniser flops = 0, so ip[7:2] = 0.
  - ip[1:0] = sw_ip, combinational and unaffected by reset.
  - Internal tick phase bit = 0.
- Synchroniser:
  - Each ext_int bit passes through a SYNC_STAGES-deep flop chain; ext_s = last stage.
  - Latency from a stable pin change to ext_s is exactly SYNC_STAGES rising edges.
  - Level-sensitive; nothing is latched.
- Count update, per rising edge:
  - If count_we: count <= count_wdata. Write beats increment.
  - Else if tick == 1: count <= count + 1, wrapping mod 2^32 (0xFFFFFFFF -> 0x00000000).
  - Else: hold.
  - The tick phase is defined under Optional Feature. count_we does not alter the tick phase.
- Compare update: if compare_we, compare <= compare_wdata on the next edge.
- TI flag, per rising edge, priority high to low:
  1. compare_we -> ti <= 0. Clearing takes priority even if a match occurs in the same cycle.
  2. Match -> ti <= 1. A match is count_next != count && count_next == compare, where compare is the pre-write value. Both an increment and a count_we can produce a match.
  3. Otherwise ti holds. It stays 1 until a Compare write; Count writes never clear it.
- No spurious TI at reset: count == compare == 0 with no count change produces no match.
- Output composition, combinational from registers:
  - ip[7] = ti | ext_s[5]
  - ip[6:2] = ext_s[4:0]
  - ip[1:0] = sw_ip
- Simultaneous count_we and compare_we:
  - Both registers load.
  - ti clears.
  - The new pair is compared from the following cycle onward.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); an in-flight write is dropped.

Optional Feature:
- Macro: CP0_COUNT_HALF_RATE_EN.
- Defined: tick toggles every cycle, so Count increments on every second edge (MIPS32 rate). After reset the first increment is at the 2nd rising edge.
- Undefined: tick is tied to 1 and Count increments every cycle. The tick flop is not instantiated.

Test Plan:
- Reset, no stimulus, macro undefined -> count = 1,2,3 on edges 1..3; ti = 0; ip = {6'b0, sw_ip}; with sw_ip = 2'b10, ip = 8'h02 throughout.
- Macro defined, 8 edges free-running -> count = 0,1,1,2,2,3,3,4.
- Write compare = 0x10 at count = 0x0C, macro undefined -> ti rises on the edge where count becomes 0x10; ip[7] = 1 thereafter and stays set through count 0x20; a subsequent compare_we (any value) clears ti the next edge.
- count_we 0xFFFFFFFE, compare = 0x00000001 -> count goes 0xFFFFFFFF, 0x00000000, 0x00000001; ti sets exactly when count = 0x00000001.
- Same cycle: compare_we = 0x50 while count is incrementing to the old compare 0x40 -> ti stays 0; the count_we/compare_we both-active case loads both registers and clears ti.
- ext_int = 6'b100001 asserted asynchronously, SYNC_STAGES = 2 -> ip = 8'h84 after 2 edges; deassert -> ip[7], ip[2] return to 0 after 2 edges (assuming ti = 0); resetn pulsed mid-way -> ip[7:2] = 0 immediately.

Source files
------------

// File: rtl/cp0_intr_timer.sv
// cp0_intr_timer: CP0 Count/Compare registers, timer-interrupt flag and Cause.IP composition.
// Define CP0_COUNT_HALF_RATE_EN to advance Count on every second clock (MIPS32 rate).

module cp0_intr_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    generate
        if (STAGES == 1) begin : g_one
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) chain <= '0;
                else         chain <= d;
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) chain <= '0;
                else         chain <= {chain[STAGES-2:0], d};
            end
        end
    endgenerate

    assign q = chain[STAGES-1];
endmodule

module cp0_intr_timer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  ext_int,
    input  logic [1:0]  sw_ip,
    input  logic        count_we,
    input  logic [31:0] count_wdata,
    input  logic        compare_we,
    input  logic [31:0] compare_wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti,
    output logic [7:0]  ip
);
    localparam int NUM_EXT = 6;

    logic [NUM_EXT-1:0] ext_s;
    logic [31:0]        count_q;
    logic [31:0]        compare_q;
    logic [31:0]        count_next;
    logic               ti_q;
    logic               tick;
    logic               match;

    generate
        for (genvar i = 0; i < NUM_EXT; i++) begin : g_sync
            cp0_intr_sync #(.STAGES(SYNC_STAGES)) u_sync (
                .clk    (clk),
                .resetn (resetn),
                .d      (ext_int[i]),
                .q      (ext_s[i])
            );
        end
    endgenerate

`ifdef CP0_COUNT_HALF_RATE_EN
    // Phase starts at 0, so the first increment lands on the second edge after reset.
    logic tick_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) tick_q <= 1'b0;
        else         tick_q <= ~tick_q;
    end
    assign tick = tick_q;
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        count_next = count_q;
        if (count_we)  count_next = count_wdata;
        else if (tick) count_next = count_q + 32'd1;
    end

    // Only a real Count change can match, so count == compare == 0 at reset stays quiet.
    assign match = (count_next != count_q) && (count_next == compare_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            count_q <= count_next;
            if (compare_we) compare_q <= compare_wdata;
            if (compare_we) ti_q <= 1'b0;
            else if (match) ti_q <= 1'b1;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;
    assign ip      = {ti_q | ext_s[5], ext_s[4:0], sw_ip};
endmodule
